// File: rtl/bitstream_const_gen.sv
// Multi-channel constant-probability unipolar bitstream generator.
// Each channel compares a committed value against a shared exact or LFSR sequence.
module bitstream_const_gen #(
    parameter int WIDTH      = 12,
    parameter int CHANNELS   = 4,
    parameter int INIT_VALUE = 75,
    parameter int SEED       = 1,
    parameter int CH_STEP    = 1,
    parameter int ROT_STEP   = 3
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic                                  en,
    input  logic                                  mode_random,
    input  logic                                  load_valid,
    output logic                                  load_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_ch,
    input  logic [WIDTH:0]                        load_value,
    output logic [CHANNELS-1:0]                   y,
    output logic                                  frame_start,
    output logic                                  active_mode
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NSLOT = 2 ** CH_W;

    localparam logic [WIDTH:0]   FULL_VAL = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   INIT_VAL = (WIDTH + 1)'(INIT_VALUE);
    localparam logic [WIDTH-1:0] SEED_RAW = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] SEED_VAL = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;

    // Right-shift Galois masks for primitive polynomials, WIDTH 4..16.
    function automatic logic [15:0] galois_taps(input int w);
        case (w)
            4:       galois_taps = 16'h000C;
            5:       galois_taps = 16'h0014;
            6:       galois_taps = 16'h0030;
            7:       galois_taps = 16'h0060;
            8:       galois_taps = 16'h00B8;
            9:       galois_taps = 16'h0110;
            10:      galois_taps = 16'h0240;
            11:      galois_taps = 16'h0500;
            12:      galois_taps = 16'h0829;
            13:      galois_taps = 16'h100D;
            14:      galois_taps = 16'h2015;
            15:      galois_taps = 16'h6000;
            16:      galois_taps = 16'hD008;
            default: galois_taps = 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]      TAPS16 = galois_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("bitstream_const_gen: WIDTH must be within 4..16");
    end

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v, input int sh);
        logic [WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < sh; i++) begin
            r = {r[WIDTH-2:0], r[WIDTH-1]};
        end
        return r;
    endfunction

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    lfsr;
    logic [WIDTH-1:0]    lfsr_next;
    logic [WIDTH:0]      active  [CHANNELS];
    logic [WIDTH:0]      pending [CHANNELS];
    logic [CHANNELS-1:0] pend_valid;
    logic [NSLOT-1:0]    pend_pad;
    logic [CHANNELS-1:0] xfer;
    logic [CHANNELS-1:0] y_next;
    logic [CHANNELS-1:0] y_q;
    logic                fs_q;
    logic                act_mode;
    logic                commit;
    logic [WIDTH:0]      load_sat;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    assign commit    = en && (cnt == '1);
    assign load_sat  = (load_value > FULL_VAL) ? FULL_VAL : load_value;

    // Load port: a word moves when load_valid && load_ready on a rising clk edge.
    // load_valid may be held while load_ready is low; the word waits. Each channel
    // owns one pending slot, so load_ready depends only on load_ch and that slot.
    // Channel indices beyond CHANNELS see ready high and their data is dropped.
    assign pend_pad   = NSLOT'(pend_valid);
    assign load_ready = ~pend_pad[load_ch];

    always_comb begin
        xfer = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            xfer[c] = load_valid && load_ready && (load_ch == CH_W'(c));
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [WIDTH-1:0] OFS = WIDTH'(c * CH_STEP);
        localparam int               ROT = (c * ROT_STEP) % WIDTH;

        logic [WIDTH-1:0] seq_exact;
        logic [WIDTH-1:0] seq_rand;
        logic [WIDTH-1:0] seq;

        assign seq_exact = bit_rev(cnt + OFS);
        assign seq_rand  = rot_left(lfsr, ROT);
        assign seq       = act_mode ? seq_rand : seq_exact;
        assign y_next[c] = ({1'b0, seq} < active[c]);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt      <= '0;
            lfsr     <= SEED_VAL;
            y_q      <= '0;
            fs_q     <= 1'b0;
            act_mode <= 1'b0;
        end else if (en) begin
            cnt  <= cnt + 1'b1;
            lfsr <= lfsr_next;
            y_q  <= y_next;
            fs_q <= (cnt == '0);
            if (commit) begin
                act_mode <= mode_random;
            end
        end
    end

    // A transfer landing on the commit edge refills the slot after commit drains it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                active[c]  <= INIT_VAL;
                pending[c] <= '0;
            end
            pend_valid <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (commit && pend_valid[c]) begin
                    active[c] <= pending[c];
                end
                if (xfer[c]) begin
                    pending[c]    <= load_sat;
                    pend_valid[c] <= 1'b1;
                end else if (commit) begin
                    pend_valid[c] <= 1'b0;
                end
            end
        end
    end

    assign y           = y_q;
    assign frame_start = fs_q;
    assign active_mode = act_mode;

endmodule

// File: tb/tb_bitstream_const_gen.sv
// Directed bench for bitstream_const_gen at WIDTH=4, CHANNELS=2, INIT_VALUE=5.
// Frame patterns are 16-bit words, bit i = output at frame position i.
module tb_bitstream_const_gen;

    localparam int WIDTH = 4;
    localparam int CHANNELS = 2;
    localparam int FRAME = 16;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             en = 1'b0;
    logic             mode_random = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [0:0]       load_ch = 1'b0;
    logic [WIDTH:0]   load_value = '0;
    logic [CHANNELS-1:0] y;
    logic             frame_start;
    logic             active_mode;

    bitstream_const_gen #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .INIT_VALUE(5),
        .SEED(1), .CH_STEP(1), .ROT_STEP(3)
    ) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .mode_random(mode_random),
        .load_valid(load_valid), .load_ready(load_ready), .load_ch(load_ch),
        .load_value(load_value), .y(y), .frame_start(frame_start),
        .active_mode(active_mode)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired before summary");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] y0_w = '0;
    logic [15:0] y1_w = '0;
    logic [15:0] fs_w = '0;
    int          pos = 0;
    logic [1:0]  last_y = '0;
    logic        last_fs = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample at the falling edge. Stalled cycles must hold outputs.
    task automatic tick();
        logic en_edge;
        en_edge = en;
        @(posedge clk);
        @(negedge clk);
        if (en_edge) begin
            if (pos < FRAME) begin
                y0_w[pos] = y[0];
                y1_w[pos] = y[1];
                fs_w[pos] = frame_start;
            end
            pos++;
        end else begin
            check_eq("stall_y", 32'(y), 32'(last_y));
            check_eq("stall_fs", 32'(frame_start), 32'(last_fs));
        end
        last_y  = y;
        last_fs = frame_start;
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 64 && pos < p; i++) begin
            tick();
        end
    endtask

    task automatic clear_frame();
        y0_w = '0;
        y1_w = '0;
        fs_w = '0;
        pos  = 0;
    endtask

    task automatic expect_frame(input logic [15:0] e0, input logic [15:0] e1);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
    endtask

    task automatic end_frame(input string tag);
        logic [15:0] e0;
        logic [15:0] e1;
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        check_eq({tag, "_len"}, 32'(pos), 32'(FRAME));
        check_eq({tag, "_y0"}, 32'(y0_w), 32'(e0));
        check_eq({tag, "_y1"}, 32'(y1_w), 32'(e1));
        check_eq({tag, "_fs"}, 32'(fs_w), 32'h0001);
        clear_frame();
    endtask

    // driver tasks
    task automatic do_load(input int ch, input int val, input logic exp_acc, input string tag);
        load_ch    = 1'(ch);
        load_value = 5'(val);
        load_valid = 1'b1;
        #1;
        check_eq(tag, 32'(load_ready), 32'(exp_acc));
        tick();
        load_valid = 1'b0;
    endtask

    task automatic check_ready(input int ch, input logic exp_rdy, input string tag);
        load_ch = 1'(ch);
        #1;
        check_eq(tag, 32'(load_ready), 32'(exp_rdy));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst_y", 32'(y), 32'h0);
        check_eq("rst_fs", 32'(frame_start), 32'h0);
        check_eq("rst_mode", 32'(active_mode), 32'h0);
        check_ready(0, 1'b1, "rst_ready");
        @(negedge clk);
        n_rst = 1'b1;
        en    = 1'b1;
        clear_frame();
        last_y  = y;
        last_fs = frame_start;

        // value 5 exact: ch0 ones at cnt {0,2,4,8,12}, ch1 one step ahead
        expect_frame(16'h1115, 16'h888A);
        run_to(16);
        check_eq("shift_rel", 32'(y1_w), 32'({y0_w[0], y0_w[15:1]}));
        end_frame("frame_a");
        expect_frame(16'h1115, 16'h888A);
        run_to(16);
        end_frame("frame_b");

        // mid-frame loads: ch0=16, ch1=0; busy second load to ch0 is refused
        expect_frame(16'h1115, 16'h888A);
        run_to(5);
        do_load(0, 16, 1'b1, "ld_c0_ready");
        do_load(1, 0, 1'b1, "ld_c1_ready");
        check_ready(0, 1'b0, "c0_pend");
        check_ready(1, 1'b0, "c1_pend");
        do_load(0, 3, 1'b0, "ld_c0_busy");
        run_to(14);
        check_ready(0, 1'b0, "c0_pend_late");
        run_to(16);
        end_frame("frame_c");
        check_ready(0, 1'b1, "c0_free");
        check_ready(1, 1'b1, "c1_free");

        // ch1=8 pending; ch0=2 transfers on the commit edge itself
        expect_frame(16'hFFFF, 16'h0000);
        run_to(10);
        do_load(1, 8, 1'b1, "ld_d1");
        run_to(15);
        do_load(0, 2, 1'b1, "ld_d0_commit");
        end_frame("frame_d");
        check_ready(0, 1'b0, "c0_pend_next");
        expect_frame(16'hFFFF, 16'hAAAA);
        run_to(16);
        end_frame("frame_e");
        check_ready(0, 1'b1, "c0_free_e");
        expect_frame(16'h0101, 16'hAAAA);
        run_to(16);
        end_frame("frame_f");

        // 7-cycle stall mid-frame with a load accepted during it
        expect_frame(16'h0101, 16'hAAAA);
        run_to(6);
        en = 1'b0;
        repeat (3) tick();
        do_load(1, 5, 1'b1, "ld_stall");
        repeat (3) tick();
        en = 1'b1;
        run_to(16);
        end_frame("frame_g");

        // switch to random mode mid-frame, ch0=9, ch1=31 saturating to 16
        expect_frame(16'h0101, 16'h888A);
        run_to(8);
        mode_random = 1'b1;
        do_load(0, 9, 1'b1, "ld_h0");
        do_load(1, 31, 1'b1, "ld_h1_sat");
        run_to(15);
        check_eq("mode_before", 32'(active_mode), 32'h0);
        tick();
        check_eq("mode_after", 32'(active_mode), 32'h1);
        end_frame("frame_h");

        // random frame: 15 consecutive bits of value 9 hold 8 ones
        run_to(16);
        check_eq("rand_len", 32'(pos), 32'(FRAME));
        check_eq("rand_y0_ones", 32'($countones(y0_w[14:0])), 32'd8);
        check_eq("rand_y1_full", 32'(y1_w), 32'hFFFF);
        check_eq("rand_fs", 32'(fs_w), 32'h0001);
        clear_frame();

        // reset mid-frame with a pending load
        run_to(4);
        mode_random = 1'b0;
        do_load(0, 3, 1'b1, "ld_j0");
        n_rst = 1'b0;
        #1;
        check_eq("mid_rst_y", 32'(y), 32'h0);
        check_eq("mid_rst_fs", 32'(frame_start), 32'h0);
        check_eq("mid_rst_mode", 32'(active_mode), 32'h0);
        check_ready(0, 1'b1, "mid_rst_pend");
        @(negedge clk);
        n_rst = 1'b1;
        clear_frame();
        last_y  = y;
        last_fs = frame_start;
        expect_frame(16'h1115, 16'h888A);
        run_to(16);
        end_frame("frame_k");
        expect_frame(16'h1115, 16'h888A);
        run_to(16);
        end_frame("frame_l");
        check_eq("final_mode", 32'(active_mode), 32'h0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
